// File: rtl/spi_pkg.sv
// Shared definitions for the synchronous-mode SPI slave: mode encodings,
// FSM states and the bit-counter width helper.
package spi_pkg;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACTIVE    = 2'd2
    } spi_state_e;

    function automatic int unsigned spi_cnt_width(input int unsigned pack_length);
        return $clog2(pack_length + 1);
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Synchronises SCLK, CS and MOSI into the system clock domain and derives
// single-cycle rise/fall strobes for the synchronised SCLK and CS.
module spi_input_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    input  logic cs_i,
    input  logic mosi_i,
    output logic cs_s_o,
    output logic mosi_s_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic cs_rise_o,
    output logic cs_fall_o
);

    // Each stage holds {sclk, cs, mosi}.
    logic [SYNC_STAGES-1:0][2:0] pipe_q;
    logic                        sclk_prev_q;
    logic                        cs_prev_q;
    logic                        sclk_s;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pipe_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            pipe_q      <= {pipe_q[SYNC_STAGES-2:0], {sclk_i, cs_i, mosi_i}};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s_o;
        end
    end

    assign sclk_s      = pipe_q[SYNC_STAGES-1][2];
    assign cs_s_o      = pipe_q[SYNC_STAGES-1][1];
    assign mosi_s_o    = pipe_q[SYNC_STAGES-1][0];
    assign sclk_rise_o = sclk_s & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_s & sclk_prev_q;
    assign cs_rise_o   = cs_s_o & ~cs_prev_q;
    assign cs_fall_o   = ~cs_s_o & cs_prev_q;

endmodule

// File: rtl/spi_slave_sync_mode.sv
// Oversampled SPI slave supporting all CPOL/CPHA modes, either bit order,
// multi-word frames, a valid/ready transmit holding register and error strobes.
module spi_slave_sync_mode
    import spi_pkg::*;
#(
    parameter int unsigned PACK_LENGTH = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   IN_CLK,
    input  logic                   IN_RESET_N,
    input  logic                   SCLK,
    input  logic                   CS,
    input  logic                   MOSI,
    output logic                   MISO,
    input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
    input  logic                   IN_TRANSMIT_VALID,
    output logic                   OUT_TRANSMIT_READY,
    output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
    output logic                   OUT_RECEIVE_VALID,
    output logic                   OUT_TX_UNDERRUN,
    output logic                   OUT_FRAME_ERROR,
    output logic                   OUT_BUSY
);

    localparam int unsigned        CNT_W    = spi_cnt_width(PACK_LENGTH);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(PACK_LENGTH);

    logic cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic sample_edge, shift_edge, word_start;

    spi_state_e             state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [PACK_LENGTH-1:0] rx_shift_q, rx_shift_d;
    logic [PACK_LENGTH-1:0] tx_shift_q, tx_shift_d;
    logic [PACK_LENGTH-1:0] hold_q, hold_d;
    logic [PACK_LENGTH-1:0] rx_data_q, rx_data_d;
    logic                   ready_q, ready_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;
    logic                   frame_err_q, frame_err_d;
    logic                   start_pend_q, start_pend_d;
    logic                   commit_pend_q, commit_pend_d;
    logic                   preview_full_q, preview_full_d;
    logic                   skip_lead_q, skip_lead_d;

    spi_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i       (IN_CLK),
        .rst_ni      (IN_RESET_N),
        .sclk_i      (SCLK),
        .cs_i        (CS),
        .mosi_i      (MOSI),
        .cs_s_o      (cs_s),
        .mosi_s_o    (mosi_s),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .cs_rise_o   (cs_rise),
        .cs_fall_o   (cs_fall)
    );

    assign sample_edge = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
    assign shift_edge  = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;

    always_ff @(posedge IN_CLK) begin
        if (!IN_RESET_N) begin
            state_q        <= ST_WAIT_IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            hold_q         <= '0;
            rx_data_q      <= '0;
            ready_q        <= 1'b1;
            rx_valid_q     <= 1'b0;
            underrun_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            start_pend_q   <= 1'b0;
            commit_pend_q  <= 1'b0;
            preview_full_q <= 1'b0;
            skip_lead_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            hold_q         <= hold_d;
            rx_data_q      <= rx_data_d;
            ready_q        <= ready_d;
            rx_valid_q     <= rx_valid_d;
            underrun_q     <= underrun_d;
            frame_err_q    <= frame_err_d;
            start_pend_q   <= start_pend_d;
            commit_pend_q  <= commit_pend_d;
            preview_full_q <= preview_full_d;
            skip_lead_q    <= skip_lead_d;
        end
    end

    // A word start only previews the holding register onto tx_shift; the pop
    // (or underrun) is committed at the word's first sample edge, so the shift
    // edge that closes a frame's last word never consumes or flags anything.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        hold_d         = hold_q;
        rx_data_d      = rx_data_q;
        ready_d        = ready_q;
        rx_valid_d     = 1'b0;
        underrun_d     = 1'b0;
        frame_err_d    = 1'b0;
        start_pend_d   = start_pend_q;
        commit_pend_d  = commit_pend_q;
        preview_full_d = preview_full_q;
        skip_lead_d    = skip_lead_q;
        word_start     = 1'b0;

        if (IN_TRANSMIT_VALID && ready_q) begin
            hold_d  = IN_TRANSMIT_DATA;
            ready_d = 1'b0;
        end

        unique case (state_q)
            ST_WAIT_IDLE: begin
                if (cs_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d      = ST_ACTIVE;
                    bit_cnt_d    = '0;
                    start_pend_d = 1'b0;
                    skip_lead_d  = CPHA;
                    word_start   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (bit_cnt_q == CNT_FULL) begin
                    rx_data_d    = rx_shift_q;
                    rx_valid_d   = 1'b1;
                    bit_cnt_d    = '0;
                    start_pend_d = 1'b1;
                end
                if (sample_edge) begin
                    rx_shift_d = MSB_FIRST ? {rx_shift_q[PACK_LENGTH-2:0], mosi_s}
                                           : {mosi_s, rx_shift_q[PACK_LENGTH-1:1]};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (commit_pend_q) begin
                        commit_pend_d = 1'b0;
                        if (preview_full_q) ready_d    = 1'b1;
                        else                underrun_d = 1'b1;
                    end
                end
                if (shift_edge) begin
                    if (start_pend_q) begin
                        start_pend_d = 1'b0;
                        word_start   = 1'b1;
                    end else if (skip_lead_q) begin
                        skip_lead_d = 1'b0;
                    end else begin
                        tx_shift_d = MSB_FIRST ? {tx_shift_q[PACK_LENGTH-2:0], 1'b0}
                                               : {1'b0, tx_shift_q[PACK_LENGTH-1:1]};
                    end
                end
                if (cs_rise) begin
                    state_d       = ST_IDLE;
                    bit_cnt_d     = '0;
                    start_pend_d  = 1'b0;
                    commit_pend_d = 1'b0;
                    skip_lead_d   = 1'b0;
                    if (bit_cnt_q != '0 && bit_cnt_q != CNT_FULL) frame_err_d = 1'b1;
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase

        if (word_start) begin
            tx_shift_d     = ready_q ? '0 : hold_q;
            preview_full_d = !ready_q;
            commit_pend_d  = 1'b1;
        end
    end

    assign MISO               = CS ? 1'bz : (MSB_FIRST ? tx_shift_q[PACK_LENGTH-1] : tx_shift_q[0]);
    assign OUT_TRANSMIT_READY = ready_q;
    assign OUT_RECEIVE_DATA   = rx_data_q;
    assign OUT_RECEIVE_VALID  = rx_valid_q;
    assign OUT_TX_UNDERRUN    = underrun_q;
    assign OUT_FRAME_ERROR    = frame_err_q;
    assign OUT_BUSY           = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_sync_mode.sv
// Directed bench: one mode-0 MSB-first slave and three LSB-first slaves
// (modes 1..3) driven by a shared bit-banged SPI master.
module tb_spi_slave_sync_mode;
    import spi_pkg::*;

    localparam int HALF = 60;
    localparam logic [1:0] MODES [4] = '{SPI_MODE0, SPI_MODE1, SPI_MODE2, SPI_MODE3};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk_raw;
    logic       mosi;
    logic [3:0] cs_n;
    logic [7:0] tx_data;
    logic [3:0] tx_valid;
    wire  [3:0] miso, ready, rx_valid, underrun, ferr, busy;
    wire  [7:0] rx_data [4];

    int checks = 0;
    int errors = 0;
    int vcnt[4] = '{default: 0};
    int ucnt[4] = '{default: 0};
    int fcnt[4] = '{default: 0};
    int acnt[4] = '{default: 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam logic [1:0] M = MODES[g];
        spi_slave_sync_mode #(
            .PACK_LENGTH (8),
            .CPOL        (M[1]),
            .CPHA        (M[0]),
            .MSB_FIRST   (g == 0),
            .SYNC_STAGES (2)
        ) u_dut (
            .IN_CLK             (clk),
            .IN_RESET_N         (rst_n),
            .SCLK               (sclk_raw ^ M[1]),
            .CS                 (cs_n[g]),
            .MOSI               (mosi),
            .MISO               (miso[g]),
            .IN_TRANSMIT_DATA   (tx_data),
            .IN_TRANSMIT_VALID  (tx_valid[g]),
            .OUT_TRANSMIT_READY (ready[g]),
            .OUT_RECEIVE_DATA   (rx_data[g]),
            .OUT_RECEIVE_VALID  (rx_valid[g]),
            .OUT_TX_UNDERRUN    (underrun[g]),
            .OUT_FRAME_ERROR    (ferr[g]),
            .OUT_BUSY           (busy[g])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valid[i] === 1'b1) vcnt[i]++;
            if (underrun[i] === 1'b1) ucnt[i]++;
            if (ferr[i] === 1'b1) fcnt[i]++;
            if (tx_valid[i] && ready[i] === 1'b1) acnt[i]++;
        end
    end

    // Master: raw SCLK idles low, so a raw rise is always the leading edge.
    task automatic spi_frame(input int idx, input int nbits, input logic [7:0] w0,
                             input logic [7:0] w1, output logic [7:0] r0, output logic [7:0] r1);
        logic       cpha;
        logic       msb;
        logic [15:0] tbits;
        logic [15:0] rbits;
        logic [7:0]  w;
        int          pos;
        cpha  = MODES[idx][0];
        msb   = (idx == 0);
        rbits = '0;
        for (int k = 0; k < 16; k++) begin
            w   = (k < 8) ? w0 : w1;
            pos = msb ? 7 - (k % 8) : (k % 8);
            tbits[k] = w[pos];
        end
        @(negedge clk);
        cs_n[idx] = 1'b0;
        if (!cpha) mosi = tbits[0];
        #100;
        for (int k = 0; k < nbits; k++) begin
            if (!cpha) begin
                sclk_raw = 1'b1;
                rbits[k] = miso[idx];
                #HALF;
                sclk_raw = 1'b0;
                if (k + 1 < 16) mosi = tbits[k+1];
                #HALF;
            end else begin
                sclk_raw = 1'b1;
                mosi     = tbits[k];
                #HALF;
                sclk_raw = 1'b0;
                rbits[k] = miso[idx];
                #HALF;
            end
        end
        #100;
        cs_n[idx] = 1'b1;
        #200;
        for (int k = 0; k < 16; k++) begin
            pos = msb ? 7 - (k % 8) : (k % 8);
            if (k < 8) r0[pos] = rbits[k];
            else       r1[pos] = rbits[k];
        end
    endtask

    task automatic load(input int idx, input logic [7:0] d);
        @(negedge clk);
        checks++;
        if (ready[idx] !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_before[%0d]: got %b expected 1", idx, ready[idx]);
        end
        tx_data       = d;
        tx_valid[idx] = 1'b1;
        @(negedge clk);
        tx_valid[idx] = 1'b0;
        checks++;
        if (ready[idx] !== 1'b0) begin
            errors++;
            $display("FAIL load_ready_after[%0d]: got %b expected 0", idx, ready[idx]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cs_n = '1; sclk_raw = 1'b0; mosi = 1'b0; tx_valid = '0; tx_data = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_data[i] !== 8'h00) begin errors++; $display("FAIL reset_rx_data[%0d]: got %h expected 00", i, rx_data[i]); end
            checks++;
            if ({rx_valid[i], underrun[i], ferr[i], busy[i]} !== 4'b0000) begin
                errors++; $display("FAIL reset_strobes[%0d]: got %b expected 0000", i, {rx_valid[i], underrun[i], ferr[i], busy[i]});
            end
            checks++;
            if (ready[i] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 1", i, ready[i]); end
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [7:0] r0, r1;
        int v0, u0;
        v0 = vcnt[0]; u0 = ucnt[0];
        load(0, 8'hA5);
        spi_frame(0, 8, 8'h3C, 8'h00, r0, r1);
        checks++; if (r0 !== 8'hA5) begin errors++; $display("FAIL mode0_miso: got %h expected a5", r0); end
        checks++; if (rx_data[0] !== 8'h3C) begin errors++; $display("FAIL mode0_rx: got %h expected 3c", rx_data[0]); end
        checks++; if (vcnt[0] - v0 !== 1) begin errors++; $display("FAIL mode0_valid_pulses: got %0d expected 1", vcnt[0] - v0); end
        checks++; if (ucnt[0] - u0 !== 0) begin errors++; $display("FAIL mode0_underrun: got %0d expected 0", ucnt[0] - u0); end
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL mode0_ready_after: got %b expected 1", ready[0]); end
    endtask

    task automatic test_modes_lsb();
        logic [7:0] r0, r1;
        int v0;
        for (int i = 1; i < 4; i++) begin
            v0 = vcnt[i];
            load(i, 8'h81);
            spi_frame(i, 8, 8'h0F, 8'h00, r0, r1);
            checks++; if (r0 !== 8'h81) begin errors++; $display("FAIL mode%0d_miso: got %h expected 81", i, r0); end
            checks++; if (rx_data[i] !== 8'h0F) begin errors++; $display("FAIL mode%0d_rx: got %h expected 0f", i, rx_data[i]); end
            checks++; if (vcnt[i] - v0 !== 1) begin errors++; $display("FAIL mode%0d_valid_pulses: got %0d expected 1", i, vcnt[i] - v0); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r0, r1;
        int v0, u0;
        v0 = vcnt[0]; u0 = ucnt[0];
        load(0, 8'h11);
        fork
            spi_frame(0, 16, 8'h12, 8'h34, r0, r1);
            begin #300; load(0, 8'h22); end
        join
        checks++; if ({r0, r1} !== 16'h1122) begin errors++; $display("FAIL b2b_miso: got %h expected 1122", {r0, r1}); end
        checks++; if (rx_data[0] !== 8'h34) begin errors++; $display("FAIL b2b_rx: got %h expected 34", rx_data[0]); end
        checks++; if (vcnt[0] - v0 !== 2) begin errors++; $display("FAIL b2b_valid_pulses: got %0d expected 2", vcnt[0] - v0); end
        checks++; if (ucnt[0] - u0 !== 0) begin errors++; $display("FAIL b2b_underrun: got %0d expected 0", ucnt[0] - u0); end

        v0 = vcnt[0]; u0 = ucnt[0];
        load(0, 8'h11);
        spi_frame(0, 16, 8'h55, 8'hAA, r0, r1);
        checks++; if ({r0, r1} !== 16'h1100) begin errors++; $display("FAIL b2b_empty_miso: got %h expected 1100", {r0, r1}); end
        checks++; if (rx_data[0] !== 8'hAA) begin errors++; $display("FAIL b2b_empty_rx: got %h expected aa", rx_data[0]); end
        checks++; if (vcnt[0] - v0 !== 2) begin errors++; $display("FAIL b2b_empty_valid: got %0d expected 2", vcnt[0] - v0); end
        checks++; if (ucnt[0] - u0 !== 1) begin errors++; $display("FAIL b2b_empty_underrun: got %0d expected 1", ucnt[0] - u0); end
    endtask

    task automatic test_frame_error();
        logic [7:0] r0, r1;
        int v0, f0;
        v0 = vcnt[0]; f0 = fcnt[0];
        load(0, 8'h5A);
        spi_frame(0, 5, 8'hF0, 8'h00, r0, r1);
        checks++; if (fcnt[0] - f0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", fcnt[0] - f0); end
        checks++; if (rx_data[0] !== 8'hAA) begin errors++; $display("FAIL ferr_rx_kept: got %h expected aa", rx_data[0]); end
        checks++; if (vcnt[0] - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", vcnt[0] - v0); end
        v0 = vcnt[0]; f0 = fcnt[0];
        load(0, 8'h3C);
        spi_frame(0, 8, 8'hC3, 8'h00, r0, r1);
        checks++; if (rx_data[0] !== 8'hC3) begin errors++; $display("FAIL ferr_next_rx: got %h expected c3", rx_data[0]); end
        checks++; if (r0 !== 8'h3C) begin errors++; $display("FAIL ferr_next_miso: got %h expected 3c", r0); end
        checks++; if (vcnt[0] - v0 !== 1 || fcnt[0] - f0 !== 0) begin
            errors++; $display("FAIL ferr_next_pulses: got valid %0d ferr %0d expected 1 0", vcnt[0] - v0, fcnt[0] - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] r0, r1;
        int v0;
        v0 = vcnt[0];
        load(0, 8'hE1);
        fork
            spi_frame(0, 8, 8'h77, 8'h00, r0, r1);
            begin
                #(100 + 4 * 2 * HALF + 30);
                @(negedge clk); rst_n = 1'b0;
                @(negedge clk); @(negedge clk);
                checks++; if (rx_data[0] !== 8'h00) begin errors++; $display("FAIL midrst_rx: got %h expected 00", rx_data[0]); end
                checks++; if ({ready[0], busy[0], rx_valid[0]} !== 3'b100) begin
                    errors++; $display("FAIL midrst_ctrl: got %b expected 100", {ready[0], busy[0], rx_valid[0]});
                end
                checks++; if (miso[0] !== 1'b0) begin errors++; $display("FAIL midrst_miso: got %b expected 0", miso[0]); end
                rst_n = 1'b1;
                @(negedge clk);
                checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b expected 0", busy[0]); end
            end
        join
        checks++; if (vcnt[0] - v0 !== 0) begin errors++; $display("FAIL midrst_valid: got %0d expected 0", vcnt[0] - v0); end
        checks++; if (rx_data[0] !== 8'h00) begin errors++; $display("FAIL midrst_rx_after: got %h expected 00", rx_data[0]); end
        v0 = vcnt[0];
        load(0, 8'h96);
        spi_frame(0, 8, 8'h69, 8'h00, r0, r1);
        checks++; if (r0 !== 8'h96) begin errors++; $display("FAIL midrst_next_miso: got %h expected 96", r0); end
        checks++; if (rx_data[0] !== 8'h69 || vcnt[0] - v0 !== 1) begin
            errors++; $display("FAIL midrst_next_rx: got %h/%0d expected 69/1", rx_data[0], vcnt[0] - v0);
        end
    endtask

    task automatic test_valid_ready();
        logic [7:0] r0, r1;
        int a0, u0;
        load(0, 8'hE7);
        a0 = acnt[0];
        @(negedge clk);
        tx_data = 8'hB4; tx_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL vr_ready_held[%0d]: got %b expected 0", c, ready[0]); end
        end
        checks++; if (acnt[0] - a0 !== 0) begin errors++; $display("FAIL vr_no_accept: got %0d expected 0", acnt[0] - a0); end
        spi_frame(0, 8, 8'h00, 8'h00, r0, r1);
        @(negedge clk); tx_valid[0] = 1'b0;
        checks++; if (r0 !== 8'hE7) begin errors++; $display("FAIL vr_first: got %h expected e7", r0); end
        checks++; if (acnt[0] - a0 !== 1) begin errors++; $display("FAIL vr_accepts: got %0d expected 1", acnt[0] - a0); end
        u0 = ucnt[0];
        spi_frame(0, 8, 8'h00, 8'h00, r0, r1);
        checks++; if (r0 !== 8'hB4) begin errors++; $display("FAIL vr_second: got %h expected b4", r0); end
        spi_frame(0, 8, 8'h00, 8'h00, r0, r1);
        checks++; if (r0 !== 8'h00) begin errors++; $display("FAIL vr_third: got %h expected 00", r0); end
        checks++; if (ucnt[0] - u0 !== 1) begin errors++; $display("FAIL vr_underrun: got %0d expected 1", ucnt[0] - u0); end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0();
        test_modes_lsb();
        test_back_to_back();
        test_frame_error();
        test_reset_mid_frame();
        test_valid_ready();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync_mode.md
Name: spi_slave_sync_mode

Overview:
Parametrised SPI slave, successor to the mode-0 edge-clocked slave. All logic runs in the system clock domain: SCLK, CS and MOSI are oversampled and synchronised, and all four CPOL/CPHA modes and both bit orders are set by parameters. Adds a valid/ready transmit buffer, a receive-valid strobe, multi-word frames under a single CS, and underrun and frame-error reporting. Sits between an external SPI master and the on-chip register/FIFO logic.

Parameters:
PACK_LENGTH, 8, bits per word (2..32)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB first on both lines; 0 = LSB first
SYNC_STAGES, 2, synchroniser depth for SCLK/CS/MOSI (>=2)

Ports:
IN_CLK  input  1  system clock; must be >= 8x the SCLK frequency
IN_RESET_N  input  1  synchronous, active-low reset
SCLK  input  1  SPI clock from master (asynchronous)
CS  input  1  chip select, active low (asynchronous)
MOSI  input  1  master-out data
MISO  output  1  slave-out data; 1'bZ while raw CS=1
IN_TRANSMIT_DATA  input  PACK_LENGTH  next word to send
IN_TRANSMIT_VALID  input  1  transmit word offered
OUT_TRANSMIT_READY  output  1  holding register empty
OUT_RECEIVE_DATA  output  PACK_LENGTH  last complete received word
OUT_RECEIVE_VALID  output  1  1-cycle strobe when a new word is complete
OUT_TX_UNDERRUN  output  1  1-cycle strobe: word started with empty holding register
OUT_FRAME_ERROR  output  1  1-cycle strobe: CS rose mid-word
OUT_BUSY  output  1  state == ACTIVE

Behaviour:
- Reset (IN_RESET_N=0 at a rising IN_CLK edge) clears synchronisers, shift registers, bit counter and holding register, and moves to WAIT_IDLE.
- Output values in reset: OUT_RECEIVE_DATA=0, all strobes=0, OUT_BUSY=0, OUT_TRANSMIT_READY=1. MISO drives 0 if CS is low, otherwise Z.
- Synchronised signals are sclk_s, cs_s, mosi_s. Edges are detected by comparing sclk_s with its previous value.
- Leading edge = rise if CPOL=0, fall if CPOL=1. Sample edge = leading edge if CPHA=0, otherwise trailing edge. Shift edge = the other edge.
- State WAIT_IDLE: moves to IDLE once cs_s=1. A reset applied mid-frame therefore never joins a frame partway through.
- State IDLE: on the cs_s falling edge, go to ACTIVE and start word 0 (the word-start action below).
- State ACTIVE:
  - Each sample edge shifts mosi_s into rx_shift (toward MSB if MSB_FIRST, else toward LSB) and increments bit_cnt.
  - When bit_cnt reaches PACK_LENGTH:
    - In the next cycle, OUT_RECEIVE_DATA takes the assembled word and OUT_RECEIVE_VALID=1 for exactly one cycle.
    - bit_cnt clears to 0.
    - A word-start action follows at the next shift edge, which supports back-to-back words.
  - Each shift edge advances tx_shift by one bit. Exception for CPHA=1: the first leading edge of each word does not shift.
  - cs_s rising edge with bit_cnt=0: go to IDLE, no error.
  - cs_s rising edge with bit_cnt!=0: OUT_FRAME_ERROR pulses, the partial word is discarded (OUT_RECEIVE_DATA unchanged, no VALID), go to IDLE.
- Word-start action:
  - If the holding register is full, tx_shift takes the holding register, which then becomes empty.
  - If it is empty, tx_shift is set to 0 and OUT_TX_UNDERRUN pulses.
- MISO = tx_shift MSB if MSB_FIRST, else tx_shift LSB, gated to Z by raw (unsynchronised) CS.
- Timing requirement for CPHA=0: the master's first SCLK edge must come at least SYNC_STAGES+2 IN_CLK cycles after CS falls.
- Transmit handshake:
  - Accept when IN_TRANSMIT_VALID && OUT_TRANSMIT_READY.
  - OUT_TRANSMIT_READY = holding register empty (registered output).
  - If an accept and an underrun word-start occur in the same cycle, the underrun still fires and the accepted word is kept for the next word.
- Data may be loaded in any state, including IDLE, before CS falls.
- OUT_RECEIVE_DATA holds its value until the next complete word.

Decomposition:
- Shared package spi_pkg holds:
  - mode localparams SPI_MODE0..3, each mapping to a {CPOL,CPHA} pair;
  - state encoding ST_WAIT_IDLE, ST_IDLE, ST_ACTIVE;
  - function clog2-based counter width.
- One sub-module, spi_input_sync: a SYNC_STAGES-deep 3-bit synchroniser with registered previous values, producing rise and fall strobes for sclk_s and cs_s.

Test Plan:
- Mode 0, MSB first:
  - Stimulus: load 8'hA5 before CS falls; master sends 8'h3C.
  - Required: MISO bits 1,0,1,0,0,1,0,1 at the sample edges; OUT_RECEIVE_DATA=8'h3C; one OUT_RECEIVE_VALID pulse; no underrun.
- Modes 1, 2 and 3 each, in an LSB_FIRST build:
  - Stimulus: TX 8'h81, RX 8'h0F.
  - Required: OUT_RECEIVE_DATA=8'h0F; master captures 8'h81.
- Two words in one CS frame:
  - Stimulus: load 8'h11; after the first word's word-start, load 8'h22.
  - Required: master receives 11,22; two VALID pulses.
  - Stimulus: the same frame with no second load.
  - Required: the second word reads 00 and OUT_TX_UNDERRUN pulses once.
- CS rises after 5 bits:
  - Required: one OUT_FRAME_ERROR pulse; OUT_RECEIVE_DATA keeps its prior value; the next full frame receives 8'hC3 correctly.
- IN_RESET_N low for 2 cycles in the middle of a word, while CS stays low:
  - Required: outputs take their reset values; the remaining SCLK edges of that frame are ignored (no VALID); the next frame works.
- Valid held high with READY low:
  - Required: no accept while READY=0; the held data is accepted on the cycle READY returns to 1, and only once.
